wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Producer end of the architectural register file's writeback (p2) and invalidation (pi) ports.
- Accepts results from the ALU and the load/store unit (LSU) over valid/ready handshakes and buffers them in a small in-order FIFO.
- Drains the FIFO at one register-file write per cycle.
- Registers dispatch-time destination invalidations so they reach the register file one cycle after the source-operand read.

Parameters:
- DEPTH, 4, number of writeback FIFO entries; power of two, at least 2.
- CW, 3, width of wb_count; equals clog2(DEPTH+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result valid
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- lsu_valid  in  1  LSU result valid
- lsu_rd  in  5  LSU destination register
- lsu_data  in  32  LSU load data
- lsu_ready  out  1  LSU result accepted this cycle when high with lsu_valid
- disp_valid  in  1  decoder dispatching an instruction that has a destination
- disp_rd  in  5  destination of the dispatched instruction
- we_p2  out  1  register-file write enable
- addr_p2  out  5  register-file write address
- din_p2  out  32  register-file write data
- we_pi  out  1  register-file invalidation enable
- addr_pi  out  5  register-file invalidation address
- wb_count  out  CW  current FIFO occupancy

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, pointers 0, wb_count=0, we_p2=0, addr_p2=0, din_p2=0, we_pi=0, addr_pi=0. Ready outputs are combinational and therefore read 1 during reset (FIFO empty). No pushes occur while reset is asserted.
- FIFO entry: {rd[4:0], data[31:0]}. Circular buffer; head and tail pointers wrap modulo DEPTH.
- Pop: the register file always accepts a write, so pop = (wb_count != 0) every cycle. No backpressure from the register file.
- Write outputs: we_p2 = (wb_count != 0), combinational from the head. addr_p2 and din_p2 come from the head entry when non-empty and are 0 when empty.
- Free slots: free = DEPTH - wb_count + pop, computed combinationally.
- LSU priority:
  - lsu_ready = (free >= 1).
  - alu_ready = (free >= 2) | ((free >= 1) & !lsu_valid).
- Handshake: a transfer occurs on a cycle where valid & ready are both high. The producer holds rd and data stable while valid is high and ready is low.
- Same-cycle acceptance: when both are accepted in one cycle, the LSU entry is enqueued first (closer to head), then the ALU entry. Up to 2 pushes and 1 pop occur per cycle.
- Latency: a result accepted at edge k onto an empty FIFO drives we_p2=1 for the cycle following edge k, and is popped at edge k+1.
- x0 results: a result with rd==0 is accepted normally (ready unaffected) but is not enqueued and never produces we_p2.
- Occupancy: wb_count_next = wb_count + pushes - pop. It never exceeds DEPTH and never underflows.
- Invalidation path, registered:
  - we_pi <= disp_valid & (disp_rd != 0).
  - addr_pi <= disp_rd when disp_valid, otherwise holds its value.
  - disp_valid is never backpressured.
- Invalidation/writeback collision: when we_pi and we_p2 target the same address in the same cycle, both are still driven. The register file gives invalidation priority; this block does not alter either.
- Ordering: the FIFO preserves acceptance order, so two writes to the same rd retire in acceptance order.
- Full boundary: with wb_count==DEPTH, pop=1 and free=1. LSU is accepted; ALU is accepted only if lsu_valid is low.

Test Plan:
- Reset mid-operation: load 3 entries, pulse reset low asynchronously between edges -> wb_count=0 and we_p2=0 immediately; alu_ready=1 and lsu_ready=1 once idle.
- Single ALU result: alu_rd=5, alu_data=0xDEADBEEF accepted at edge k -> we_p2=1, addr_p2=5, din_p2=0xDEADBEEF for exactly one cycle after k; wb_count returns to 0.
- Dual push: lsu {rd=3, data=0x11} and alu {rd=4, data=0x22} in the same cycle on an empty FIFO -> writes rd3/0x11 then rd4/0x22 on consecutive cycles.
- Full FIFO (DEPTH=4): both valid every cycle for 6 cycles -> wb_count saturates at 4; while full, lsu_ready=1 and alu_ready=0; no entry lost; output order matches acceptance order across pointer wrap.
- x0 filtering: alu_rd=0 with alu_data=0x55 and alu_valid=1 -> alu_ready=1, no we_p2, wb_count unchanged; disp_valid=1 with disp_rd=0 -> we_pi stays 0.
- Invalidation timing: disp_valid=1, disp_rd=7 at edge k -> we_pi=1, addr_pi=7 during cycle k+1; we_pi=0 in the following cycle if disp_valid is low; a same-cycle we_p2 to rd7 is still driven unchanged.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results into an in-order FIFO drained one
// register-file write per cycle, and registers dispatch-time destination invalidations.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    output logic          alu_ready,
    input  logic          lsu_valid,
    input  logic [4:0]    lsu_rd,
    input  logic [31:0]   lsu_data,
    output logic          lsu_ready,
    input  logic          disp_valid,
    input  logic [4:0]    disp_rd,
    output logic          we_p2,
    output logic [4:0]    addr_p2,
    output logic [31:0]   din_p2,
    output logic          we_pi,
    output logic [4:0]    addr_pi,
    output logic [CW-1:0] wb_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] tail_alu;
    logic [CW-1:0] count;
    logic [CW:0]   free;
    logic          pop;
    logic          lsu_push;
    logic          alu_push;

    // The register file never stalls, so any occupied head retires this cycle.
    assign pop  = (count != '0);
    assign free = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};

    // LSU gets the last free slot; ALU needs a spare one unless LSU is idle.
    assign lsu_ready = (free >= (CW+1)'(1));
    assign alu_ready = (free >= (CW+1)'(2)) | (lsu_ready & ~lsu_valid);

    // x0 results complete the handshake but are dropped instead of enqueued.
    assign lsu_push = lsu_valid & lsu_ready & (lsu_rd != 5'd0);
    assign alu_push = alu_valid & alu_ready & (alu_rd != 5'd0);
    assign tail_alu = tail + AW'(lsu_push);

    always_ff @(posedge clk) begin
        if (lsu_push) begin
            mem_rd[tail]   <= lsu_rd;
            mem_data[tail] <= lsu_data;
        end
        if (alu_push) begin
            mem_rd[tail_alu]   <= alu_rd;
            mem_data[tail_alu] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop);
            tail  <= tail_alu + AW'(alu_push);
            count <= count + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
        end
    end

    always_comb begin
        we_p2   = pop;
        addr_p2 = '0;
        din_p2  = '0;
        if (pop) begin
            addr_p2 = mem_rd[head];
            din_p2  = mem_data[head];
        end
    end

    assign wb_count = count;

    // Invalidation lands one cycle after dispatch; addr_pi holds when nothing dispatches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_pi   <= 1'b0;
            addr_pi <= '0;
        end else begin
            we_pi <= disp_valid & (disp_rd != 5'd0);
            if (disp_valid) begin
                addr_pi <= disp_rd;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts readiness,
// occupancy and invalidations; a monitor retires expected writes as the DUT presents them.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0;
    logic [4:0]    alu_rd = '0;
    logic [31:0]   alu_data = '0;
    logic          alu_ready;
    logic          lsu_valid = 1'b0;
    logic [4:0]    lsu_rd = '0;
    logic [31:0]   lsu_data = '0;
    logic          lsu_ready;
    logic          disp_valid = 1'b0;
    logic [4:0]    disp_rd = '0;
    logic          we_p2;
    logic [4:0]    addr_p2;
    logic [31:0]   din_p2;
    logic          we_pi;
    logic [4:0]    addr_pi;
    logic [CW-1:0] wb_count;

    int checks = 0;
    int errors = 0;

    // model_fifo mirrors architectural occupancy; sb_q holds writes the monitor still expects.
    logic [36:0] model_fifo[$];
    logic [36:0] sb_q[$];
    logic        exp_we_pi = 1'b0;
    logic [4:0]  exp_addr_pi = '0;

    wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .disp_valid(disp_valid), .disp_rd(disp_rd),
        .we_p2(we_p2), .addr_p2(addr_p2), .din_p2(din_p2),
        .we_pi(we_pi), .addr_pi(addr_pi), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: drive at negedge, check predicted state, then advance the model at posedge.
    task automatic applyStimulus(
        input  logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input  logic av, input logic [4:0] ard, input logic [31:0] ad,
        input  logic dv, input logic [4:0] drd,
        output logic l_acc, output logic a_acc);
        int   size;
        int   free;
        logic exp_l;
        logic exp_a;
        @(negedge clk);
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        disp_valid = dv; disp_rd = drd;
        #1;
        size  = model_fifo.size();
        free  = DEPTH - size + ((size > 0) ? 1 : 0);
        exp_l = (free >= 1);
        exp_a = (free >= 2) || ((free >= 1) && !lv);
        checkOutput("lsu_ready", lsu_ready, exp_l);
        checkOutput("alu_ready", alu_ready, exp_a);
        checkOutput("wb_count", wb_count, size);
        checkOutput("we_pi", we_pi, exp_we_pi);
        checkOutput("addr_pi", addr_pi, exp_addr_pi);
        l_acc = lv && exp_l;
        a_acc = av && exp_a;
        @(posedge clk);
        if (size > 0) void'(model_fifo.pop_front());
        if (l_acc && lrd != 5'd0) begin
            model_fifo.push_back({lrd, ld});
            sb_q.push_back({lrd, ld});
        end
        if (a_acc && ard != 5'd0) begin
            model_fifo.push_back({ard, ad});
            sb_q.push_back({ard, ad});
        end
        exp_we_pi = dv && (drd != 5'd0);
        if (dv) exp_addr_pi = drd;
    endtask

    task automatic idle(input int n);
        logic la;
        logic aa;
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, la, aa);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        lsu_valid = 1'b0; alu_valid = 1'b0; disp_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_wb_count", wb_count, 0);
        checkOutput("rst_we_p2", we_p2, 0);
        checkOutput("rst_addr_p2", addr_p2, 0);
        checkOutput("rst_din_p2", din_p2, 0);
        checkOutput("rst_we_pi", we_pi, 0);
        checkOutput("rst_addr_pi", addr_pi, 0);
        checkOutput("rst_alu_ready", alu_ready, 1);
        checkOutput("rst_lsu_ready", lsu_ready, 1);
        model_fifo.delete();
        sb_q.delete();
        exp_we_pi = 1'b0;
        exp_addr_pi = '0;
        #1 reset = 1'b1;
    endtask

    // Monitor: every presented write must be the oldest outstanding expected write.
    always @(negedge clk) begin
        logic [36:0] exp;
        if (reset) begin
            checkOutput("we_p2", we_p2, (sb_q.size() != 0));
            if (we_p2 && sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                checkOutput("addr_p2", addr_p2, exp[36:32]);
                checkOutput("din_p2", din_p2, exp[31:0]);
            end else if (!we_p2) begin
                checkOutput("addr_p2_idle", addr_p2, 0);
                checkOutput("din_p2_idle", din_p2, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic       la;
        logic       aa;
        logic       r_lv;
        logic       r_av;
        logic [4:0] r_lrd;
        logic [4:0] r_ard;
        logic [31:0] r_ld;
        logic [31:0] r_ad;
        int         l_idx;
        int         a_idx;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("init_wb_count", wb_count, 0);
        checkOutput("init_we_p2", we_p2, 0);
        checkOutput("init_addr_p2", addr_p2, 0);
        checkOutput("init_din_p2", din_p2, 0);
        checkOutput("init_we_pi", we_pi, 0);
        checkOutput("init_addr_pi", addr_pi, 0);
        checkOutput("init_alu_ready", alu_ready, 1);
        checkOutput("init_lsu_ready", lsu_ready, 1);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] single ALU result");
        applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, la, aa);
        idle(3);

        $display("[TB] dual push");
        applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0, la, aa);
        idle(3);

        $display("[TB] full FIFO with wrap");
        l_idx = 0;
        a_idx = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 5'(8 + l_idx), 32'h100 + l_idx, 1, 5'(16 + a_idx), 32'h200 + a_idx, 0, 0, la, aa);
            if (la) l_idx++;
            if (aa) a_idx++;
        end
        idle(DEPTH + 2);

        $display("[TB] x0 filtering");
        applyStimulus(0, 0, 0, 1, 5'd0, 32'h55, 1, 5'd0, la, aa);
        idle(2);

        $display("[TB] invalidation timing and collision");
        applyStimulus(0, 0, 0, 1, 5'd7, 32'hA7A7A7A7, 1, 5'd7, la, aa);
        idle(2);

        $display("[TB] reset mid-operation");
        applyStimulus(1, 5'd9, 32'h901, 1, 5'd10, 32'ha01, 1, 5'd12, la, aa);
        applyStimulus(1, 5'd11, 32'h902, 1, 5'd13, 32'ha02, 0, 0, la, aa);
        pulseReset();
        idle(2);

        $display("[TB] randomized traffic");
        r_lv = 1'b0; r_av = 1'b0; la = 1'b0; aa = 1'b0;
        r_lrd = '0; r_ard = '0; r_ld = '0; r_ad = '0;
        for (int i = 0; i < 300; i++) begin
            if (!(r_lv && !la)) begin
                r_lv  = 1'($urandom_range(0, 1));
                r_lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r_ld  = $urandom;
            end
            if (!(r_av && !aa)) begin
                r_av  = 1'($urandom_range(0, 1));
                r_ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r_ad  = $urandom;
            end
            applyStimulus(r_lv, r_lrd, r_ld, r_av, r_ard, r_ad,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), la, aa);
        end
        idle(DEPTH + 3);
        checkOutput("drain_outstanding", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
